// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - two-wide register rename stage (RAT + circular free list); optional trace under RENAME_TRACE_EN
module rename_stage #(
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 64,
    parameter int PREG_W    = 6
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [2*$clog2(NUM_AREGS)-1:0]   i_asrc0,
    input  logic [2*$clog2(NUM_AREGS)-1:0]   i_asrc1,
    input  logic [2*$clog2(NUM_AREGS)-1:0]   i_adst,
    input  logic [1:0]                       i_regwrite,
    input  logic                             i_dn_ready,
    output logic                             o_valid,
    output logic [2*PREG_W-1:0]              o_psrc0,
    output logic [2*PREG_W-1:0]              o_psrc1,
    output logic [2*PREG_W-1:0]              o_pdst,
    output logic [2*PREG_W-1:0]              o_pold,
    input  logic [1:0]                       i_free_valid,
    input  logic [2*PREG_W-1:0]              i_free_preg,
    output logic [PREG_W-1:0]                o_free_count
);

    localparam int AREG_W   = $clog2(NUM_AREGS);
    localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int FL_PTR_W = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam logic [PREG_W:0]   FL_DEPTH_C = (PREG_W+1)'(FL_DEPTH);
    localparam logic [FL_PTR_W:0] FL_WRAP_C  = (FL_PTR_W+1)'(FL_DEPTH);

    // Architectural state: alias table and circular free list
    logic [PREG_W-1:0]   rat [NUM_AREGS];
    logic [PREG_W-1:0]   fl  [FL_DEPTH];
    logic [FL_PTR_W-1:0] head;
    logic [FL_PTR_W-1:0] tail;
    logic [PREG_W-1:0]   count;

    // Per-slot unpacked views of the flattened input buses
    logic [AREG_W-1:0] asrc0 [2];
    logic [AREG_W-1:0] asrc1 [2];
    logic [AREG_W-1:0] adst  [2];
    logic [PREG_W-1:0] fpreg [2];

    logic              accept;
    logic              alloc0;
    logic              alloc1;
    logic [PREG_W-1:0] new0;
    logic [PREG_W-1:0] new1;
    logic [PREG_W-1:0] psrc0_n [2];
    logic [PREG_W-1:0] psrc1_n [2];
    logic [PREG_W-1:0] pdst_n  [2];
    logic [PREG_W-1:0] pold_n  [2];

    logic [1:0]          nalloc;
    logic [PREG_W:0]     cnt_after_alloc;
    logic                f0_ok;
    logic                f1_ok;
    logic [FL_PTR_W-1:0] tail_lane1;
    logic [FL_PTR_W-1:0] head_next;
    logic [FL_PTR_W-1:0] tail_next;
    logic [PREG_W:0]     count_next;

    // Pointer advance with explicit wrap so non-power-of-two depths work too
    function automatic logic [FL_PTR_W-1:0] ptr_add(input logic [FL_PTR_W-1:0] p, input logic [1:0] n);
        logic [FL_PTR_W:0] s;
        s = {1'b0, p} + {{(FL_PTR_W-1){1'b0}}, n};
        if (s >= FL_WRAP_C) begin
            s = s - FL_WRAP_C;
        end
        return s[FL_PTR_W-1:0];
    endfunction

    // Source lookup; arch 0 is hardwired to p0 regardless of table contents
    function automatic logic [PREG_W-1:0] rat_rd(input logic [AREG_W-1:0] a);
        return (a == '0) ? '0 : rat[a];
    endfunction

    assign o_ready      = (count >= PREG_W'(2)) && (!o_valid || i_dn_ready);
    assign accept       = i_valid && o_ready;
    assign o_free_count = count;

    // Split flattened buses into per-slot fields
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            asrc0[k] = i_asrc0[k*AREG_W +: AREG_W];
            asrc1[k] = i_asrc1[k*AREG_W +: AREG_W];
            adst[k]  = i_adst[k*AREG_W +: AREG_W];
            fpreg[k] = i_free_preg[k*PREG_W +: PREG_W];
        end
    end

    // Rename the group: allocation, table reads, intra-group bypass
    always_comb begin
        alloc0 = i_regwrite[0] && (adst[0] != '0);
        alloc1 = i_regwrite[1] && (adst[1] != '0);
        new0   = fl[head];
        new1   = alloc0 ? fl[ptr_add(head, 2'd1)] : fl[head];

        psrc0_n[0] = rat_rd(asrc0[0]);
        psrc1_n[0] = rat_rd(asrc1[0]);
        pdst_n[0]  = alloc0 ? new0 : '0;
        pold_n[0]  = alloc0 ? rat[adst[0]] : '0;

        // Slot1 sees slot0's write as if the pair were sequential
        psrc0_n[1] = (alloc0 && (asrc0[1] == adst[0])) ? new0 : rat_rd(asrc0[1]);
        psrc1_n[1] = (alloc0 && (asrc1[1] == adst[0])) ? new0 : rat_rd(asrc1[1]);
        pdst_n[1]  = alloc1 ? new1 : '0;
        if (!alloc1) begin
            pold_n[1] = '0;
        end else if (alloc0 && (adst[1] == adst[0])) begin
            pold_n[1] = new0;
        end else begin
            pold_n[1] = rat[adst[1]];
        end
    end

    // Free-list bookkeeping: legal frees, pointer and count updates
    always_comb begin
        nalloc          = accept ? ({1'b0, alloc0} + {1'b0, alloc1}) : 2'd0;
        cnt_after_alloc = {1'b0, count} - {{(PREG_W-1){1'b0}}, nalloc};
        f0_ok = i_free_valid[0] && (fpreg[0] != '0) && (cnt_after_alloc < FL_DEPTH_C);
        f1_ok = i_free_valid[1] && (fpreg[1] != '0) &&
                ((cnt_after_alloc + {{PREG_W{1'b0}}, f0_ok}) < FL_DEPTH_C);
        tail_lane1 = ptr_add(tail, {1'b0, f0_ok});
        head_next  = ptr_add(head, nalloc);
        tail_next  = ptr_add(tail, {1'b0, f0_ok} + {1'b0, f1_ok});
        count_next = cnt_after_alloc + {{PREG_W{1'b0}}, f0_ok} + {{PREG_W{1'b0}}, f1_ok};
    end

    // Alias table update; slot1 written last so it owns a shared destination
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                rat[i] <= PREG_W'(i);
            end
        end else if (accept) begin
            if (alloc0) begin
                rat[adst[0]] <= new0;
            end
            if (alloc1) begin
                rat[adst[1]] <= new1;
            end
        end
    end

    // Free-list storage, pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl[i] <= PREG_W'(NUM_AREGS + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= PREG_W'(FL_DEPTH);
        end else begin
            if (f0_ok) begin
                fl[tail] <= fpreg[0];
            end
            if (f1_ok) begin
                fl[tail_lane1] <= fpreg[1];
            end
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next[PREG_W-1:0];
        end
    end

    // Output register: load on accept, hold while stalled, drop when drained
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_psrc0 <= '0;
            o_psrc1 <= '0;
            o_pdst  <= '0;
            o_pold  <= '0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_psrc0 <= {psrc0_n[1], psrc0_n[0]};
            o_psrc1 <= {psrc1_n[1], psrc1_n[0]};
            o_pdst  <= {pdst_n[1], pdst_n[0]};
            o_pold  <= {pold_n[1], pold_n[0]};
        end else if (i_dn_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef RENAME_TRACE_EN
    // Trace accepted groups and dropped frees
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (accept) begin
                for (int k = 0; k < 2; k++) begin
                    $display("rename slot%0d: x%0d->p%0d old p%0d src x%0d->p%0d x%0d->p%0d count %0d",
                             k, adst[k], pdst_n[k], pold_n[k], asrc0[k], psrc0_n[k],
                             asrc1[k], psrc1_n[k], count_next);
                end
            end
            if (i_free_valid[0] && !f0_ok) begin
                $display("RENAME ERROR: free lane0 p%0d dropped", fpreg[0]);
            end
            if (i_free_valid[1] && !f1_ok) begin
                $display("RENAME ERROR: free lane1 p%0d dropped", fpreg[1]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - scoreboard bench for rename_stage
module tb_rename_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [9:0]  i_asrc0;
    logic [9:0]  i_asrc1;
    logic [9:0]  i_adst;
    logic [1:0]  i_regwrite;
    logic        i_dn_ready;
    logic        o_valid;
    logic [11:0] o_psrc0;
    logic [11:0] o_psrc1;
    logic [11:0] o_pdst;
    logic [11:0] o_pold;
    logic [1:0]  i_free_valid;
    logic [11:0] i_free_preg;
    logic [5:0]  o_free_count;

    rename_stage dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_asrc0      (i_asrc0),
        .i_asrc1      (i_asrc1),
        .i_adst       (i_adst),
        .i_regwrite   (i_regwrite),
        .i_dn_ready   (i_dn_ready),
        .o_valid      (o_valid),
        .o_psrc0      (o_psrc0),
        .o_psrc1      (o_psrc1),
        .o_pdst       (o_pdst),
        .o_pold       (o_pold),
        .i_free_valid (i_free_valid),
        .i_free_preg  (i_free_preg),
        .o_free_count (o_free_count)
    );

    typedef struct {
        string name;
        int    cnt;
        bit    rdy;
        bit    vld;
        int    mode;   // 0 status only, 1 outputs equal pending entry, 2 outputs zero, 3 scoreboard empty
    } probe_t;

    logic [47:0] sb [$];
    probe_t      pq [$];
    int          n_vec = 0;
    int          n_bad = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // {pold, pdst, psrc1, psrc0}, slot1 in the upper half of each field
    function automatic logic [47:0] pk(input int a0, input int b0, input int c0, input int d0,
                                       input int a1, input int b1, input int c1, input int d1);
        return {6'(d1), 6'(d0), 6'(c1), 6'(c0), 6'(b1), 6'(b0), 6'(a1), 6'(a0)};
    endfunction

    // Monitor: status probes first, then scoreboard pop on each handshake
    always @(negedge i_clk) begin
        probe_t      p;
        logic [47:0] act;
        logic [47:0] exp;
        act = {o_pold, o_pdst, o_psrc1, o_psrc0};
        if (pq.size() > 0) begin
            p = pq.pop_front();
            n_vec++;
            if (p.mode == 3) begin
                if (sb.size() != 0) begin
                    n_bad++;
                    $display("FAIL %s: %0d outputs still pending, required 0", p.name, sb.size());
                end
            end else begin
                if (o_free_count != 6'(p.cnt) || o_ready != p.rdy || o_valid != p.vld) begin
                    n_bad++;
                    $display("FAIL %s: count=%0d ready=%0d valid=%0d, required count=%0d ready=%0d valid=%0d",
                             p.name, o_free_count, o_ready, o_valid, p.cnt, p.rdy, p.vld);
                end
                if (p.mode == 1) begin
                    exp = (sb.size() > 0) ? sb[0] : 48'hffff_ffff_ffff;
                    if (act !== exp) begin
                        n_bad++;
                        $display("FAIL %s_hold: outputs %h, required %h", p.name, act, exp);
                    end
                end else if (p.mode == 2 && act !== 48'h0) begin
                    n_bad++;
                    $display("FAIL %s_zero: outputs %h, required 0", p.name, act);
                end
            end
        end
        if (o_valid && i_dn_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: outputs %h, required none", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL rename_out: pold=%h pdst=%h psrc1=%h psrc0=%h, required pold=%h pdst=%h psrc1=%h psrc0=%h",
                             act[47:36], act[35:24], act[23:12], act[11:0],
                             exp[47:36], exp[35:24], exp[23:12], exp[11:0]);
                end
            end
        end
    end

    task automatic probe(input string name, input int cnt, input bit rdy, input bit vld, input int mode);
        probe_t p;
        p.name = name;
        p.cnt  = cnt;
        p.rdy  = rdy;
        p.vld  = vld;
        p.mode = mode;
        pq.push_back(p);
    endtask

    task automatic present(input logic [4:0] s00, input logic [4:0] s01, input logic [4:0] d0, input logic w0,
                           input logic [4:0] s10, input logic [4:0] s11, input logic [4:0] d1, input logic w1,
                           input logic [47:0] e);
        i_asrc0    = {s10, s00};
        i_asrc1    = {s11, s01};
        i_adst     = {d1, d0};
        i_regwrite = {w1, w0};
        i_valid    = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wait_accept();
        int b;
        b = 0;
        @(negedge i_clk);
        while (!o_ready) begin
            b++;
            if (b > 60) begin
                $display("FAIL accept_timeout: o_ready=%0d, required 1", o_ready);
                $fatal(1);
            end
            @(negedge i_clk);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send(input logic [4:0] s00, input logic [4:0] s01, input logic [4:0] d0, input logic w0,
                        input logic [4:0] s10, input logic [4:0] s11, input logic [4:0] d1, input logic w1,
                        input logic [47:0] e);
        present(s00, s01, d0, w0, s10, s11, d1, w1, e);
        wait_accept();
    endtask

    // Let any pending output drain, then pulse reset
    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    // Chain of double-alloc groups: slot0 x10<-x1,x2 ; slot1 x11<-x10,x0
    task automatic run_chain(input int n);
        for (int i = 0; i < n; i++) begin
            send(5'd1, 5'd2, 5'd10, 1'b1, 5'd10, 5'd0, 5'd11, 1'b1,
                 pk(1, 2, 32 + 2*i, (i == 0) ? 10 : 30 + 2*i,
                    32 + 2*i, 0, 33 + 2*i, (i == 0) ? 11 : 31 + 2*i));
        end
    endtask

    task automatic free_pair(input logic [1:0] v, input logic [5:0] p1, input logic [5:0] p0);
        i_free_valid = v;
        i_free_preg  = {p1, p0};
        @(posedge i_clk);
        #1;
        i_free_valid = 2'b00;
        i_free_preg  = '0;
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_valid      = 1'b0;
        i_asrc0      = '0;
        i_asrc1      = '0;
        i_adst       = '0;
        i_regwrite   = '0;
        i_dn_ready   = 1'b1;
        i_free_valid = '0;
        i_free_preg  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        probe("reset_state", 32, 1'b1, 1'b0, 2);

        // Basic pair with bypass of x5
        send(5'd1, 5'd2, 5'd5, 1'b1, 5'd5, 5'd3, 5'd6, 1'b1, pk(1, 2, 32, 5, 32, 3, 33, 6));
        probe("first_group", 30, 1'b1, 1'b1, 0);

        // Same destination in both slots, then read it
        do_reset();
        send(5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, pk(0, 0, 32, 7, 0, 0, 33, 32));
        send(5'd7, 5'd5, 5'd8, 1'b0, 5'd7, 5'd7, 5'd0, 1'b1, pk(33, 5, 0, 0, 33, 33, 0, 0));
        probe("same_dst", 30, 1'b1, 1'b1, 0);

        // Both slots non-allocating
        do_reset();
        send(5'd3, 5'd4, 5'd0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, pk(3, 4, 0, 0, 9, 0, 0, 0));
        probe("no_alloc", 32, 1'b1, 1'b1, 0);

        // Exhaust the free list, wrap-around refill
        do_reset();
        run_chain(16);
        probe("exhausted", 0, 1'b0, 1'b1, 0);
        free_pair(2'b11, 6'd6, 6'd5);
        probe("refilled", 2, 1'b1, 1'b0, 0);
        send(5'd10, 5'd11, 5'd12, 1'b1, 5'd12, 5'd0, 5'd13, 1'b1, pk(62, 63, 5, 12, 5, 0, 6, 13));
        probe("realloc", 0, 1'b0, 1'b1, 0);

        // Illegal frees are dropped
        do_reset();
        send(5'd0, 5'd0, 5'd1, 1'b1, 5'd0, 5'd0, 5'd4, 1'b0, pk(0, 0, 32, 1, 0, 0, 0, 0));
        probe("single_alloc", 31, 1'b1, 1'b1, 0);
        free_pair(2'b11, 6'd45, 6'd44);
        probe("free_saturate", 32, 1'b1, 1'b0, 0);
        free_pair(2'b11, 6'd0, 6'd40);
        probe("free_drop", 32, 1'b1, 1'b0, 0);
        send(5'd0, 5'd0, 5'd2, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, pk(0, 0, 33, 2, 0, 0, 34, 3));

        // Downstream stall with a queued pair
        do_reset();
        send(5'd2, 5'd3, 5'd1, 1'b1, 5'd1, 5'd0, 5'd2, 1'b1, pk(2, 3, 32, 1, 32, 0, 33, 2));
        i_dn_ready = 1'b0;
        present(5'd1, 5'd2, 5'd3, 1'b1, 5'd3, 5'd4, 5'd4, 1'b0, pk(32, 33, 34, 3, 34, 4, 0, 0));
        for (int c = 0; c < 3; c++) begin
            probe("stall", 30, 1'b0, 1'b1, 1);
            @(posedge i_clk);
            #1;
        end
        i_dn_ready = 1'b1;
        wait_accept();
        probe("after_stall", 29, 1'b1, 1'b1, 0);

        // Reset in the middle of a stream
        do_reset();
        run_chain(6);
        probe("count_20", 20, 1'b1, 1'b1, 0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        probe("async_reset", 32, 1'b1, 1'b0, 2);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        send(5'd21, 5'd22, 5'd20, 1'b1, 5'd24, 5'd25, 5'd23, 1'b1, pk(21, 22, 32, 20, 24, 25, 33, 23));

        repeat (3) @(posedge i_clk);
        #1;
        probe("drained", 0, 1'b0, 1'b0, 3);
        repeat (2) @(posedge i_clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
